// File: rtl/synth_audio_pkg.sv
// Shared types and constants for the synthesizer audio output path.
package synth_audio_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int FRAME_SLOTS = 32;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic [4:0]                 slot_t;

  localparam slot_t LAST_SLOT = slot_t'(FRAME_SLOTS - 1);

  // Word select runs one slot ahead of each channel's MSB.
  function automatic logic ws_for(input slot_t s);
    return (s >= 5'd15) && (s != LAST_SLOT);
  endfunction

endpackage

// File: rtl/i2s_clock_gen.sv
// I2S bit-clock divider and slot sequencer.
module i2s_clock_gen
  import synth_audio_pkg::*;
#(
  parameter int BCLK_HALF = 4
) (
  input  logic  clk,
  input  logic  reset,
  output logic  bclk_o,
  output logic  shift_o,
  output slot_t slot_o,
  output logic  lrclk_o
);

  localparam logic [7:0] DIV_TC = 8'(BCLK_HALF - 1);

  logic [7:0] div_q;
  logic       bclk_q;
  slot_t      slot_q;
  slot_t      slot_d;
  logic       lrclk_q;
  logic       tc;

  assign tc      = (div_q == DIV_TC);
  // A terminal count while bclk is high is the falling edge.
  assign shift_o = tc & bclk_q;
  assign slot_d  = shift_o ? slot_q + 5'd1 : slot_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      bclk_q  <= 1'b0;
      slot_q  <= LAST_SLOT;
      lrclk_q <= 1'b0;
    end else begin
      div_q   <= tc ? 8'd0 : div_q + 8'd1;
      bclk_q  <= tc ? ~bclk_q : bclk_q;
      slot_q  <= slot_d;
      lrclk_q <= ws_for(slot_d);
    end
  end

  assign bclk_o  = bclk_q;
  assign slot_o  = slot_q;
  assign lrclk_o = lrclk_q;

endmodule

// File: rtl/synth_i2s_transmitter.sv
// Mono sample stream to I2S serialiser with one-word holding buffer.
module synth_i2s_transmitter
  import synth_audio_pkg::*;
#(
  parameter int BCLK_HALF = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  sample_t sample,
  input  logic    sample_valid,
  output logic    sample_ready,
  output logic    i2s_bclk,
  output logic    i2s_lrclk,
  output logic    i2s_data,
  output logic    frame_start,
  output logic    underrun
);

  logic    shift_evt;
  slot_t   slot;
  slot_t   slot_nxt;
  logic    load;
  logic    accept;

  sample_t hold_q, hold_d;
  sample_t last_q, last_d;
  sample_t shift_q, shift_d;
  logic    full_q, full_d;
  logic    data_q, data_d;
  logic    fs_q, fs_d;
  logic    ur_q, ur_d;

  i2s_clock_gen #(
    .BCLK_HALF(BCLK_HALF)
  ) u_clk (
    .clk    (clk),
    .reset  (reset),
    .bclk_o (i2s_bclk),
    .shift_o(shift_evt),
    .slot_o (slot),
    .lrclk_o(i2s_lrclk)
  );

  assign load     = shift_evt && (slot == LAST_SLOT);
  assign accept   = sample_valid && !full_q;
  assign slot_nxt = slot + 5'd1;

  always_comb begin
    hold_d  = hold_q;
    last_d  = last_q;
    shift_d = shift_q;
    full_d  = full_q;
    data_d  = data_q;
    fs_d    = 1'b0;
    ur_d    = 1'b0;
    // Load uses the pre-capture holding state; no bypass.
    if (load) begin
      fs_d = 1'b1;
      ur_d = !full_q;
      if (full_q) begin
        shift_d = hold_q;
        last_d  = hold_q;
        full_d  = 1'b0;
      end else begin
        shift_d = last_q;
      end
    end
    if (accept) begin
      hold_d = sample;
      full_d = 1'b1;
    end
    if (shift_evt) begin
      data_d = shift_d[4'hF - slot_nxt[3:0]];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q  <= '0;
      last_q  <= '0;
      shift_q <= '0;
      full_q  <= 1'b0;
      data_q  <= 1'b0;
      fs_q    <= 1'b0;
      ur_q    <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      last_q  <= last_d;
      shift_q <= shift_d;
      full_q  <= full_d;
      data_q  <= data_d;
      fs_q    <= fs_d;
      ur_q    <= ur_d;
    end
  end

  assign sample_ready = !full_q;
  assign i2s_data     = data_q;
  assign frame_start  = fs_q;
  assign underrun     = ur_q;

endmodule

// File: tb/tb_synth_i2s_transmitter.sv
// Scoreboard bench for synth_i2s_transmitter with BCLK_HALF=2.
module tb_synth_i2s_transmitter;
  import synth_audio_pkg::*;

  localparam int HB    = 2;
  localparam int FRAME = 64 * HB;
  localparam int FIRST = 2 * HB;

  logic    clk = 1'b0;
  logic    reset = 1'b1;
  sample_t sample = '0;
  logic    sample_valid = 1'b0;
  logic    sample_ready;
  logic    i2s_bclk;
  logic    i2s_lrclk;
  logic    i2s_data;
  logic    frame_start;
  logic    underrun;

  int checks = 0;
  int errors = 0;
  int frames_done = 0;
  int n = 0;

  logic [16:0] sbq[$];
  logic        m_full = 1'b0;
  sample_t     m_hold = '0;
  sample_t     m_last = '0;

  always #5 clk = ~clk;

  synth_i2s_transmitter #(
    .BCLK_HALF(HB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample      (sample),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrclk   (i2s_lrclk),
    .i2s_data    (i2s_data),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Frame-level model: which word each frame must carry.
  always @(posedge clk) begin : model
    logic acc;
    if (reset) begin
      n = 0;
      m_full = 1'b0;
      m_hold = '0;
      m_last = '0;
      sbq.delete();
    end else begin
      acc = sample_valid && !m_full;
      n = n + 1;
      if (n >= FIRST && (n - FIRST) % FRAME == 0) begin
        if (m_full) begin
          sbq.push_back({1'b0, m_hold});
          m_last = m_hold;
          m_full = 1'b0;
        end else begin
          sbq.push_back({1'b1, m_last});
        end
      end
      if (acc) begin
        m_hold = sample;
        m_full = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) chk("ready", 32'(sample_ready), 32'(!m_full));
  end

  initial begin : mon
    forever begin
      logic [16:0] e;
      logic [31:0] d, lr, lrx, hi, lo;
      bit ab;
      while (reset || !frame_start) @(negedge clk);
      if (sbq.size() == 0) begin
        chk("sb_empty", 32'(sbq.size()), 32'd1);
        e = '0;
      end else begin
        e = sbq.pop_front();
      end
      chk("underrun", 32'(underrun), 32'(e[16]));
      ab = 1'b0;
      d = '0; lr = '0; lrx = '0; hi = '0; lo = '0;
      for (int s = 0; s < 32 && !ab; s++) begin
        repeat (HB) begin
          @(negedge clk);
          if (reset) ab = 1'b1;
        end
        hi[31-s]  = i2s_bclk;
        d[31-s]   = i2s_data;
        lr[31-s]  = i2s_lrclk;
        lrx[31-s] = (s >= 15 && s <= 30);
        repeat (HB) begin
          @(negedge clk);
          if (reset) ab = 1'b1;
        end
        lo[31-s] = i2s_bclk;
      end
      if (!ab) begin
        chk("data", d, {e[15:0], e[15:0]});
        chk("lrclk", lr, lrx);
        chk("bclk_hi", hi, 32'hFFFF_FFFF);
        chk("bclk_lo", lo, 32'h0);
        chk("fs_period", 32'(frame_start), 32'd1);
        frames_done++;
      end
    end
  end

  task automatic push(input sample_t w, output int waited);
    waited = 0;
    sample = w;
    sample_valid = 1'b1;
    while (!sample_ready && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (!sample_ready) chk("push_timeout", 32'(sample_ready), 32'd1);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_frames(input int k);
    int tgt;
    int c;
    tgt = frames_done + k;
    c = 0;
    while (frames_done < tgt && c < k * FRAME + 400) begin
      @(negedge clk);
      c++;
    end
    chk("frame_wait", 32'(frames_done >= tgt), 32'd1);
  endtask

  task automatic first_fs(input string tag);
    int k;
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      k++;
      if (frame_start) break;
    end
    chk(tag, 32'(k), 32'(FIRST));
    chk({tag, "_ur"}, 32'(underrun), 32'd1);
  endtask

  task automatic wait_fs();
    int k;
    k = 0;
    while (!frame_start && k < FRAME + 50) begin
      @(negedge clk);
      k++;
    end
    chk("fs_wait", 32'(frame_start), 32'd1);
  endtask

  task automatic wait_pre_load();
    int k;
    k = 0;
    while (!(n >= FIRST - 1 && (n - (FIRST - 1)) % FRAME == 0)
           && k < FRAME + 50) begin
      @(negedge clk);
      k++;
    end
    chk("pre_load", 32'(sample_ready), 32'd1);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_bclk"}, 32'(i2s_bclk), 32'd0);
    chk({tag, "_lr"}, 32'(i2s_lrclk), 32'd0);
    chk({tag, "_data"}, 32'(i2s_data), 32'd0);
    chk({tag, "_fs"}, 32'(frame_start), 32'd0);
    chk({tag, "_ur"}, 32'(underrun), 32'd0);
    chk({tag, "_rdy"}, 32'(sample_ready), 32'd1);
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : stim
    int w;
    repeat (3) @(negedge clk);
    reset_vals("rst");
    reset = 1'b0;
    first_fs("first_fs");
    wait_frames(2);

    do_reset();
    push(16'h8001, w);
    chk("ready_drop", 32'(sample_ready), 32'd0);
    wait_fs();
    chk("ready_back", 32'(sample_ready), 32'd1);
    push(16'h1234, w);
    wait_frames(3);
    chk("ready_idle", 32'(sample_ready), 32'd1);

    wait_pre_load();
    sample = 16'h5A5A;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    chk("load_fs", 32'(frame_start), 32'd1);
    wait_frames(3);

    push(16'hBEEF, w);
    push(16'h0A0A, w);
    chk("a_refused", 32'(w > 0), 32'd1);
    wait_frames(3);

    wait_fs();
    push(16'h7777, w);
    repeat (2 * HB * 9 + HB - 1) @(negedge clk);
    #1 reset = 1'b1;
    #1 reset_vals("rst_mid");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    first_fs("first_fs_2");
    wait_frames(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/synth_i2s_transmitter.md
Name: synth_i2s_transmitter

Overview:
- Consumes the 16-bit signed mono sample stream produced by the synthesizer and serialises it onto a standard I2S link: bit clock, word select and serial data, with the same word on left and right.
- Sits between the synthesizer's sample output and the board audio DAC/codec pins.
- Exposes a valid/ready sample handshake and a one-word holding buffer.
- Reuses the last sample and flags an underrun when the synthesizer has not supplied a new word in time.

Parameters:
- BCLK_HALF, 4, clk cycles per half bit-clock period; legal range 2..255.
- SAMPLE_W, 16, sample width in bits; fixed by the package, and any other value is illegal.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- sample  in  16  signed sample (shortint) from the synthesizer.
- sample_valid  in  1  sample is presented this cycle.
- sample_ready  out  1  holding buffer empty; the word is accepted when valid & ready.
- i2s_bclk  out  1  serial bit clock.
- i2s_lrclk  out  1  word select; 0 = left, 1 = right.
- i2s_data  out  1  serial data, MSB first.
- frame_start  out  1  one-clk pulse when a new word loads into the shift register.
- underrun  out  1  one-clk pulse, coincident with frame_start, when the holding buffer was empty at load.

Behaviour:
- Reset values: i2s_bclk=0, i2s_lrclk=0, i2s_data=0, frame_start=0, underrun=0.
- Reset state: holding buffer empty, so sample_ready=1. last_sample=0, shift=0, div_cnt=0, slot=31.
- Reset asserted mid-frame aborts the frame immediately and returns to the reset values; any held sample is discarded.

Bit-clock divider:
- div_cnt counts 0..BCLK_HALF-1; on terminal count it wraps and i2s_bclk toggles.
- When the toggle is 1->0 (falling edge), a "shift event" occurs in that same cycle.
- Frame length is 32 bclk periods = 64*BCLK_HALF clk cycles.

Slot counter:
- slot (5 bits) increments modulo 32 at each shift event. The first shift event after reset moves slot 31->0.
- i2s_lrclk = 1 when slot is in 15..30, else 0. Word select therefore leads the MSB by one bclk (I2S delay).
- i2s_data = shift[15 - (slot mod 16)], registered; it changes only at shift events, so it is stable across the rising bclk edge.

Frame load (at the shift event where slot goes 31->0):
- If holding is full: shift <= holding, last_sample <= holding, holding emptied, frame_start=1, underrun=0.
- If holding is empty: shift <= last_sample, frame_start=1, underrun=1.
- The right channel retransmits the same shift word during slots 16..31. The shift register is not modified mid-frame.

Handshake:
- sample_ready = ~holding_full (registered state, no combinational path from sample_valid).
- On valid & ready the word is captured into holding; ready drops the next cycle.
- Valid & ready in the same cycle as a frame load: the load sees the pre-capture holding state, so no bypass. With holding empty this is an underrun, and the new word is stored for the next frame. With holding full, ready was already 0.
- Valid while ready=0: the word is ignored, and the source must hold it.

Arithmetic: sample is treated as two's complement and transmitted bit-exact; no scaling or saturation.

Decomposition:
- Package synth_audio_pkg: localparam SAMPLE_W=16, FRAME_SLOTS=32; typedef logic signed [SAMPLE_W-1:0] sample_t; typedef logic [4:0] slot_t.
- Sub-module i2s_clock_gen (parameter BCLK_HALF). Outputs bclk, shift-event strobe, slot and lrclk.
- The top level keeps the holding buffer, last_sample, the shift register and the handshake.

Test Plan:
- Reset, BCLK_HALF=2, no samples -> first frame_start 4 clk after reset with underrun=1; data all 0; lrclk low for slots 31,0..14 and high for 15..30; bclk period 4 clk.
- Push 16'h8001 before the first load -> accepted (ready 1->0); at the next frame start ready returns to 1. Data reads 1000_0000_0000_0001 in slots 0..15, then the same 16 bits in slots 16..31; underrun=0.
- Push 16'h1234, then supply nothing -> the next frame repeats 16'h1234 with underrun=1; ready stays 1.
- Present valid exactly in the load cycle with holding empty -> that frame sends last_sample with underrun=1; the new word is sent in the following frame with underrun=0.
- Push A while holding already holds B -> A is refused (ready=0) until B loads; the source holds A and it is then accepted, so the order is B then A.
- Assert reset mid-frame at slot 9 -> all outputs return to reset values within the reset cycle; after release, timing restarts exactly as in scenario 1.
